ahb_mtx_arbiter_param: RTL

AHB_MTX_ARBITER_PARAM -- requirements
Module: ahb_mtx_arbiter_param

---
 rtl/ahb_mtx_arbiter_param.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ahb_mtx_arbiter_param.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_mtx_arbiter_param
//  Description : Arbiter in front of one shared AHB slave. It grants one of
//                NUM_PORTS requesting ports, either round-robin or by fixed
//                priority, and holds the grant for the length of a burst or
//                while the slave is locked.
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_mtx_arbiter_param #(
    parameter int NUM_PORTS        = 4,
    parameter int PORT_AW          = 3,
    parameter int ARB_MODE         = 0,
    parameter int INCR_HOLD_BEATS  = 4,
    parameter int EARLY_INCR_LIMIT = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_AW-1:0]   addr_in_port,
    output logic                 no_port,
    output logic                 burst_hold,
    output logic                 arb_switch
);

    localparam logic [1:0] c_TRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_TRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_TRANS_NONSEQ = 2'b10;
    localparam logic [3:0] c_INCR_REMAIN  = 4'(INCR_HOLD_BEATS - 2);
    localparam logic [1:0] c_EARLY_LIMIT  = 2'(EARLY_INCR_LIMIT);

    logic [3:0]         r_remain;
    logic               r_hold;
    logic [1:0]         r_early;
    logic               r_no_port;
    logic [PORT_AW-1:0] r_addr;
    logic               r_switch;

    logic [3:0]         w_nxt_remain;
    logic               w_nxt_hold;
    logic [1:0]         w_early_inc;
    logic [1:0]         w_nxt_early;
    logic               w_nxt_no_port;
    logic [PORT_AW-1:0] w_nxt_addr;

    logic               w_hi_found, w_lo_found, w_any_found;
    logic [PORT_AW-1:0] w_hi_pick, w_lo_pick, w_any_pick;

    // Early-termination counter: a NONSEQ arriving while a hold is still
    // active ends the previous burst early, and that termination already
    // counts when deciding whether this new INCR gets a hold.
    always_comb begin
        w_early_inc = r_early;
        if (r_hold && (HTRANSM == c_TRANS_NONSEQ) && (r_early != 2'd3)) begin
            w_early_inc = r_early + 2'd1;
        end
        w_nxt_early = w_nxt_hold ? w_early_inc : 2'd0;
    end

    // Burst tracker: beats remaining after the current one and hold flag.
    always_comb begin
        w_nxt_remain = r_remain;
        w_nxt_hold   = r_hold;
        if (!HSELM) begin
            w_nxt_remain = 4'd0;
            w_nxt_hold   = 1'b0;
        end else begin
            case (HTRANSM)
                c_TRANS_IDLE: begin
                    w_nxt_remain = 4'd0;
                    w_nxt_hold   = 1'b0;
                end
                c_TRANS_BUSY: begin
                    w_nxt_remain = r_remain;
                    w_nxt_hold   = r_hold;
                end
                c_TRANS_NONSEQ: begin
                    case (HBURSTM)
                        3'b000: begin
                            w_nxt_remain = 4'd0;
                            w_nxt_hold   = 1'b0;
                        end
                        3'b001: begin
                            if (w_early_inc == c_EARLY_LIMIT) begin
                                w_nxt_remain = 4'd0;
                                w_nxt_hold   = 1'b0;
                            end else begin
                                w_nxt_remain = c_INCR_REMAIN;
                                w_nxt_hold   = 1'b1;
                            end
                        end
                        3'b010, 3'b011: begin
                            w_nxt_remain = 4'd2;
                            w_nxt_hold   = 1'b1;
                        end
                        3'b100, 3'b101: begin
                            w_nxt_remain = 4'd6;
                            w_nxt_hold   = 1'b1;
                        end
                        default: begin
                            w_nxt_remain = 4'd14;
                            w_nxt_hold   = 1'b1;
                        end
                    endcase
                end
                default: begin
                    // SEQ: count down, release once the last beat is seen
                    if (r_remain == 4'd0) begin
                        w_nxt_remain = 4'd0;
                        w_nxt_hold   = 1'b0;
                    end else begin
                        w_nxt_remain = r_remain - 4'd1;
                        w_nxt_hold   = r_hold;
                    end
                end
            endcase
        end
    end

    // Request search: lowest requester above the current grant, below it,
    // and overall. Descending loop so the lowest index is written last.
    always_comb begin
        w_hi_found  = 1'b0;
        w_lo_found  = 1'b0;
        w_any_found = 1'b0;
        w_hi_pick   = '0;
        w_lo_pick   = '0;
        w_any_pick  = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (req_port[p]) begin
                if (p >= int'(r_addr)) begin
                    w_hi_found = 1'b1;
                    w_hi_pick  = PORT_AW'(p + 1);
                end
                if ((p + 1) < int'(r_addr)) begin
                    w_lo_found = 1'b1;
                    w_lo_pick  = PORT_AW'(p + 1);
                end
                w_any_found = 1'b1;
                w_any_pick  = PORT_AW'(p + 1);
            end
        end
    end

    // Grant decision: frozen under lock or burst hold, otherwise re-arbitrated.
    always_comb begin
        w_nxt_no_port = r_no_port;
        w_nxt_addr    = r_addr;
        if (!(HMASTLOCKM || w_nxt_hold)) begin
            if (r_no_port) begin
                if (w_any_found) begin
                    w_nxt_no_port = 1'b0;
                    w_nxt_addr    = w_any_pick;
                end
            end else if (ARB_MODE == 0) begin
                if (w_hi_found) begin
                    w_nxt_addr = w_hi_pick;
                end else if (w_lo_found) begin
                    w_nxt_addr = w_lo_pick;
                end else if (!HSELM) begin
                    w_nxt_no_port = 1'b1;
                end
            end else begin
                if (w_any_found) begin
                    w_nxt_addr = w_any_pick;
                end else if (!HSELM) begin
                    w_nxt_no_port = 1'b1;
                end
            end
        end
    end

    // State registers: everything advances only on accepted (HREADYM) edges.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_remain  <= 4'd0;
            r_hold    <= 1'b0;
            r_early   <= 2'd0;
            r_no_port <= 1'b1;
            r_addr    <= '0;
            r_switch  <= 1'b0;
        end else begin
            r_switch <= HREADYM && ({w_nxt_no_port, w_nxt_addr} != {r_no_port, r_addr});
            if (HREADYM) begin
                r_remain  <= w_nxt_remain;
                r_hold    <= w_nxt_hold;
                r_early   <= w_nxt_early;
                r_no_port <= w_nxt_no_port;
                r_addr    <= w_nxt_addr;
            end
        end
    end

    assign addr_in_port = r_addr;
    assign no_port      = r_no_port;
    assign burst_hold   = r_hold;
    assign arb_switch   = r_switch;

endmodule
`default_nettype wire
